// File: rtl/dmem_arbiter_pkg.sv
// Data-memory sharing types: word widths, arbiter FSM states, requester ids.
// No logic; imported by every dmem_arbiter file.
package dmem_arbiter_pkg;

   localparam int DM_AW = 24;
   localparam int DM_DW = 24;

   typedef enum logic {ARB = 1'b0, LOCK = 1'b1} fsm_t;
   typedef enum logic {CPU = 1'b0, HOST = 1'b1} port_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, host and memory-side signals of the shared data-memory port.
// slave = arbiter side, master = requesters plus memory model.
interface dmem_arbiter_if
   import dmem_arbiter_pkg::*;
#(
   parameter int AW = DM_AW,
   parameter int DW = DM_DW
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;

   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_lock;
   logic          host_gnt;
   logic [DW-1:0] host_rdata;

   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  host_req, host_we, host_addr, host_wdata, host_lock,
      input  mem_dout,
      output cpu_gnt, cpu_rdata, cpu_stall,
      output host_gnt, host_rdata,
      output mem_we, mem_addr, mem_din
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output host_req, host_we, host_addr, host_wdata, host_lock,
      output mem_dout,
      input  cpu_gnt, cpu_rdata, cpu_stall,
      input  host_gnt, host_rdata,
      input  mem_we, mem_addr, mem_din
   );

endinterface

// File: rtl/dmem_arbiter_arb_rr2.sv
// Two-way round-robin grant, combinational from requests and last winner.
// Latency 0; a losing requester simply sees no grant and holds its request.
module arb_rr2
   import dmem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic cpu_req,
   input  logic host_req,
   output logic cpu_gnt,
   output logic host_gnt
);

   port_t last_gnt;

   always_comb begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
      if (cpu_req && host_req) begin
         cpu_gnt  = (last_gnt == HOST);
         host_gnt = (last_gnt == CPU);
      end else begin
         cpu_gnt  = cpu_req;
         host_gnt = host_req;
      end
   end

   // Reset to HOST so the CPU wins the first conflict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_gnt <= HOST;
      else if (cpu_gnt)
         last_gnt <= CPU;
      else if (host_gnt)
         last_gnt <= HOST;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between CPU and host: round-robin plus bounded host lock.
// Latency 0 (combinational grant and read); losers are stalled, CPU stall freezes the PC.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int AW        = DM_AW,
   parameter int DW        = DM_DW,
   parameter int MAX_BURST = 8,
   parameter int SCW       = 16
)(
   input  logic           clk,
   input  logic           rst_n,
   dmem_arbiter_if.slave  bus,
   output logic [SCW-1:0] stall_cnt
);

   localparam int             BCW       = $clog2(MAX_BURST + 1);
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
   localparam bit             LOCK_EN   = (MAX_BURST > 1);

   fsm_t           fsm, fsm_nx;
   logic [BCW-1:0] burst_cnt, burst_nx;
   logic           cpu_req_m, host_req_m;
   logic           cpu_gnt, host_gnt, cpu_stall;
   logic [AW-1:0]  addr_sel;
   logic [DW-1:0]  din_sel;

   // Requests are masked during reset so no grant or write can leak out.
   assign cpu_req_m  = bus.cpu_req & rst_n & (fsm == ARB);
   assign host_req_m = bus.host_req & rst_n;

   arb_rr2 u_rr (
      .clk      (clk),
      .rst_n    (rst_n),
      .cpu_req  (cpu_req_m),
      .host_req (host_req_m),
      .cpu_gnt  (cpu_gnt),
      .host_gnt (host_gnt)
   );

   always_comb begin
      fsm_nx   = fsm;
      burst_nx = burst_cnt;
      case (fsm)
         ARB: begin
            if (LOCK_EN && host_gnt && bus.host_lock) begin
               fsm_nx   = LOCK;
               burst_nx = BCW'(1);
            end
         end
         LOCK: begin
            if (!host_gnt || !bus.host_lock || burst_cnt == LAST_BEAT) begin
               fsm_nx   = ARB;
               burst_nx = '0;
            end else begin
               burst_nx = burst_cnt + BCW'(1);
            end
         end
         default: begin
            fsm_nx   = ARB;
            burst_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm       <= ARB;
         burst_cnt <= '0;
      end else begin
         fsm       <= fsm_nx;
         burst_cnt <= burst_nx;
      end
   end

   assign addr_sel = host_gnt ? bus.host_addr  : bus.cpu_addr;
   assign din_sel  = host_gnt ? bus.host_wdata : bus.cpu_wdata;

   assign bus.mem_addr   = addr_sel;
   assign bus.mem_din    = din_sel;
   assign bus.mem_we     = (cpu_gnt & bus.cpu_we) | (host_gnt & bus.host_we);
   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.host_gnt   = host_gnt;
   assign bus.cpu_rdata  = bus.mem_dout;
   assign bus.host_rdata = bus.mem_dout;

   assign cpu_stall     = bus.cpu_req & rst_n & ~cpu_gnt;
   assign bus.cpu_stall = cpu_stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (cpu_stall && stall_cnt != '1)
         stall_cnt <= stall_cnt + SCW'(1);
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed stimulus against a behavioural model; scoreboard queue checked on negedge.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int MAX_BURST = 8;
   localparam int SCW       = 16;
   localparam int SAT       = (1 << SCW) - 1;

   typedef struct {
      bit          cg;
      bit          hg;
      bit          we;
      bit          stall;
      logic [23:0] addr;
      logic [23:0] din;
      logic [23:0] rdata;
      int          scnt;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [SCW-1:0] stall_cnt;

   dmem_arbiter_if bus ();

   dmem_arbiter #(
      .AW        (DM_AW),
      .DW        (DM_DW),
      .MAX_BURST (MAX_BURST),
      .SCW       (SCW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   // Memory environment: combinational read, write at the clock edge.
   bit [23:0] tbmem [16];
   assign bus.mem_dout = tbmem[bus.mem_addr[3:0]];
   always @(posedge clk) if (bus.mem_we) tbmem[bus.mem_addr[3:0]] <= bus.mem_din;

   exp_t sb [$];
   exp_t me;
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model: who owns memory, how long the host has held it, stall total.
   bit        m_locked    = 1'b0;
   bit        m_last_host = 1'b1;
   int        m_beats     = 0;
   int        m_stalls    = 0;
   bit [23:0] ref_mem [16];
   bit        last_cg, last_hg;

   task automatic step(input bit rst, input bit cr, input bit cw, input logic [23:0] ca,
                       input logic [23:0] cd, input bit hr, input bit hw,
                       input logic [23:0] ha, input logic [23:0] hd, input bit hl);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n          = rst;
      bus.cpu_req    = cr;
      bus.cpu_we     = cw;
      bus.cpu_addr   = ca;
      bus.cpu_wdata  = cd;
      bus.host_req   = hr;
      bus.host_we    = hw;
      bus.host_addr  = ha;
      bus.host_wdata = hd;
      bus.host_lock  = hl;

      e.cg = 1'b0;
      e.hg = 1'b0;
      if (!rst) begin
         m_locked    = 1'b0;
         m_last_host = 1'b1;
         m_beats     = 0;
         m_stalls    = 0;
      end else if (m_locked) begin
         e.hg = hr;
      end else if (cr && hr) begin
         e.cg = m_last_host;
         e.hg = !m_last_host;
      end else begin
         e.cg = cr;
         e.hg = hr;
      end
      e.we    = (e.cg && cw) || (e.hg && hw);
      e.addr  = e.hg ? ha : ca;
      e.din   = e.hg ? hd : cd;
      e.rdata = ref_mem[e.addr[3:0]];
      e.stall = rst && cr && !e.cg;
      e.scnt  = m_stalls;
      sb.push_back(e);
      last_cg = e.cg;
      last_hg = e.hg;

      if (rst) begin
         if (e.stall && m_stalls < SAT) m_stalls++;
         if (e.we) ref_mem[e.addr[3:0]] = e.din;
         if (e.cg) m_last_host = 1'b0;
         if (e.hg) m_last_host = 1'b1;
         if (m_locked) begin
            if (!e.hg || !hl || m_beats + 1 == MAX_BURST) begin
               m_locked = 1'b0;
               m_beats  = 0;
            end else begin
               m_beats++;
            end
         end else if (e.hg && hl && MAX_BURST > 1) begin
            m_locked = 1'b1;
            m_beats  = 1;
         end
      end
   endtask

   task automatic idle(input bit rst);
      step(rst, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         me = sb.pop_front();
         chk("cpu_gnt",    32'(bus.cpu_gnt),    32'(me.cg));
         chk("host_gnt",   32'(bus.host_gnt),   32'(me.hg));
         chk("cpu_stall",  32'(bus.cpu_stall),  32'(me.stall));
         chk("mem_we",     32'(bus.mem_we),     32'(me.we));
         chk("mem_addr",   32'(bus.mem_addr),   32'(me.addr));
         chk("mem_din",    32'(bus.mem_din),    32'(me.din));
         chk("cpu_rdata",  32'(bus.cpu_rdata),  32'(me.rdata));
         chk("host_rdata", 32'(bus.host_rdata), 32'(me.rdata));
         chk("stall_cnt",  32'(stall_cnt),      32'(me.scnt));
      end
   end

   initial begin
      bit          cr, cw, hr, hw, hl, rst;
      logic [23:0] ca, cd, ha, hd;

      rst_n          = 1'b0;
      bus.cpu_req    = 1'b0;
      bus.cpu_we     = 1'b0;
      bus.cpu_addr   = '0;
      bus.cpu_wdata  = '0;
      bus.host_req   = 1'b0;
      bus.host_we    = 1'b0;
      bus.host_addr  = '0;
      bus.host_wdata = '0;
      bus.host_lock  = 1'b0;

      // Reset with requests present: nothing may be granted or written.
      idle(1'b0);
      step(1'b0, 1'b1, 1'b1, 24'h5, 24'h123, 1'b1, 1'b1, 24'h6, 24'h456, 1'b1);

      // CPU write straight out of reset, then read it back.
      step(1'b1, 1'b1, 1'b1, 24'h2, 24'h00ABCD, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 24'h2, 24'h0, 1'b0, 1'b0, 24'h0, 24'h0, 1'b0);

      // Read conflict: CPU, host, CPU.
      idle(1'b0);
      repeat (3) step(1'b1, 1'b1, 1'b0, 24'h1, 24'h0, 1'b1, 1'b0, 24'h2, 24'h0, 1'b0);

      // Host burst lock against a permanently requesting CPU.
      idle(1'b0);
      for (int i = 0; i < 12; i++)
         step(1'b1, 1'b1, 1'b0, 24'h3, 24'h0, 1'b1, 1'b1, 24'(4 + i % 8), 24'(32'h100 + i), 1'b1);

      // Early unlock on beat 3.
      idle(1'b0);
      for (int i = 0; i < 5; i++)
         step(1'b1, i > 0, 1'b0, 24'h7, 24'h0, 1'b1, 1'b0, 24'h8, 24'h0, i < 2);

      // Host drops its request while locked.
      idle(1'b0);
      for (int i = 0; i < 5; i++)
         step(1'b1, i > 0, 1'b1, 24'h9, 24'(32'h900 + i), i != 2, 1'b1, 24'hA, 24'(32'hA00 + i), 1'b1);

      // Reset during beat 4 of a host write burst.
      idle(1'b0);
      for (int i = 0; i < 8; i++)
         step(i != 4, i > 0, 1'b0, 24'hB, 24'h0, 1'b1, 1'b1, 24'hC, 24'(32'hC00 + i), 1'b1);

      // Random traffic; a requester holds its fields until granted.
      cr = 1'b0;
      hr = 1'b0;
      cw = 1'b0; hw = 1'b0;
      ca = '0; cd = '0; ha = '0; hd = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!cr || last_cg) begin
            cr = ($urandom_range(0, 3) != 0);
            cw = 1'($urandom_range(0, 1));
            ca = 24'($urandom_range(0, 15));
            cd = 24'($urandom);
         end
         if (!hr || last_hg) begin
            hr = ($urandom_range(0, 2) != 0);
            hw = 1'($urandom_range(0, 1));
            ha = 24'($urandom_range(0, 15));
            hd = 24'($urandom);
         end
         hl  = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 499) != 0);
         step(rst, cr, cw, ca, cd, hr, hw, ha, hd, hl);
      end

      for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d scoreboard entries left, expected 0", sb.size());
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the CPU load/store path and a host requester, such as a program/data loader or debug probe.
- Round-robin arbitration between the two requesters.
- Optional host burst lock, bounded by MAX_BURST beats.
- Drives a CPU stall that gates the program-counter write enable, so the single-cycle core freezes while it does not own memory.
- Sits between the memory block and the CPU datapath (ALU result = write data, register operand = address).

Parameters:
- AW, 24, address width (matches datapath word).
- DW, 24, data width.
- MAX_BURST, 8, maximum consecutive host grants under lock (>=1).
- SCW, 16, stall-counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU memory access request
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_rdata  out  DW  read data, valid when cpu_gnt & ~cpu_we
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes PC and register write
- host_req  in  1  host request
- host_we  in  1  host write / read
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_lock  in  1  host asks to keep ownership for following beats
- host_gnt  out  1  host access performed this cycle
- host_rdata  out  DW  read data, valid when host_gnt & ~host_we
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data (combinational read)
- stall_cnt  out  SCW  saturating count of cpu_stall cycles

Behaviour:
- Grants are combinational from the current state and this cycle's requests; at most one grant per cycle. State updates on the rising clk edge.
- mem_we = granted port's we & its gnt; otherwise 0.
- mem_addr/mem_din = granted port's signals; CPU port's signals when no grant.
- cpu_rdata = host_rdata = mem_dout (pass-through). Read latency 0; write commits at the edge ending the grant cycle.
- State: fsm {ARB, LOCK}, last_gnt {CPU, HOST}, burst_cnt (clog2(MAX_BURST+1) bits), stall_cnt.
- Reset (async, rst_n=0): fsm=ARB, last_gnt=HOST (CPU wins first conflict), burst_cnt=0, stall_cnt=0.
- Reset values of combinational outputs: all gnt=0, mem_we=0, cpu_stall=0.
- ARB, only one req: grant it.
- ARB, both req: grant the port other than last_gnt.
- ARB, no req: no grant, state unchanged.
- ARB, any grant: last_gnt <= granted port.
- ARB, host granted with host_lock=1 and MAX_BURST>1: fsm <= LOCK, burst_cnt <= 1. With MAX_BURST=1, lock is ignored.
- LOCK: CPU never granted. host_gnt = host_req; each host grant increments burst_cnt.
- LOCK -> ARB when any of the following holds:
  - host_req=0 (cycle with no grant);
  - host granted with host_lock=0;
  - host granted and burst_cnt+1 == MAX_BURST (this beat is the last).
- On LOCK exit: last_gnt=HOST, burst_cnt <= 0, so a pending CPU request wins the next cycle.
- Simultaneous events:
  - host asserts lock while the CPU wins round-robin: no lock is entered.
  - lock deasserted on the same cycle as the MAX_BURST-th beat: single exit, no double count.
- stall_cnt increments each cycle cpu_stall=1; saturates at all-ones.
- Reset mid-lock: returns to ARB immediately; no memory write occurs while rst_n=0, because gnt=0.
- Port inputs are assumed stable while req is high; no internal buffering of requests.

Decomposition:
- Shared package (CPU-wide): AW/DW word widths, enum for fsm {ARB, LOCK}, port-id constants CPU=0/HOST=1.
- One natural sub-module: arb_rr2, the 2-way round-robin grant with last-grant register.
- The LOCK FSM, burst counter, datapath mux and stall counter stay in dmem_arbiter.

Test Plan:
- Reset then CPU write: cpu_req=1, we=1, addr=0x000002, wdata=0x00ABCD, host idle -> cpu_gnt=1, cpu_stall=0, mem_we=1, mem_addr=2 the same cycle; stall_cnt stays 0.
- Conflict after reset: both req reads, addr CPU=0x1, host=0x2 -> cycle0 cpu_gnt; cycle1 host_gnt (mem_addr=2); cycle2 cpu_gnt. During cycle1 cpu_stall=1; stall_cnt=1 after cycle1.
- Burst lock with MAX_BURST=8: host_req=host_lock=1 for 12 cycles with CPU requesting throughout -> host_gnt for exactly 8 consecutive cycles, then cpu_gnt in cycle 9, host_gnt in cycle 10; stall_cnt=8.
- Early unlock: host locks, drops host_lock on beat 3 -> beats 1-3 granted to host, next cycle to CPU; burst_cnt returns to 0.
- Host drops req in LOCK: host_req=0 at beat 2 -> no grant that cycle unless in ARB; the following cycle CPU is granted; fsm=ARB.
- Reset mid-lock: rst_n=0 during beat 4 -> all gnt=0, mem_we=0 immediately. After release, CPU wins the first conflict and stall_cnt=0.
